// File: rtl/mult_seq_v2.sv
// Iterative shift-add multiplier: retires R multiplier bits per cycle over W/R cycles,
// signed/unsigned per operation, valid/ready on both operand and result sides.
module mult_seq_v2 #(
    parameter int W = 8,
    parameter int R = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_signed,
    input  logic [W-1:0]   dA,
    input  logic [W-1:0]   dB,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] a_mult_b,
    output logic [1:0]     dbg_state_o
);

    localparam int NSTEP = W / R;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int AW    = 2 * W + 1;

    if ((R < 1) || (R > W) || ((W % R) != 0)) begin : gen_bad_r
        $error("mult_seq_v2: R must divide W");
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and the result is held stable until out_ready.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [W:0]       mag_a_q, mag_a_d;
    logic [W:0]       mag_b_q, mag_b_d;
    logic             neg_q, neg_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   res_q, res_d;

    logic [R-1:0]     slice;
    logic [AW-1:0]    partial;
    logic [AW-1:0]    acc_sum;
    logic             last_step;

    // W+1 bits so that the most negative operand has an exact magnitude.
    function automatic logic [W:0] mag_of(input logic [W-1:0] v, input logic sgn);
        logic [W:0] ext;
        ext = {sgn & v[W-1], v};
        return (sgn && v[W-1]) ? (~ext + 1'b1) : ext;
    endfunction

    always_comb begin
        slice     = mag_b_q[R-1:0];
        partial   = (AW'(mag_a_q) * AW'(slice)) << (int'(cnt_q) * R);
        acc_sum   = acc_q + partial;
        last_step = (cnt_q == CW'(NSTEP - 1));
    end

    always_comb begin
        state_d = state_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mag_a_d = mag_of(dA, in_signed);
                    mag_b_d = mag_of(dB, in_signed);
                    neg_d   = in_signed & (dA[W-1] ^ dB[W-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d   = acc_sum;
                mag_b_d = mag_b_q >> R;
                cnt_d   = cnt_q + 1'b1;
                if (last_step) begin
                    // Negating a zero magnitude yields zero, so no negative zero appears.
                    res_d   = (2*W)'(neg_q ? (~acc_sum + 1'b1) : acc_sum);
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign a_mult_b    = res_q;
    assign dbg_state_o = state_q;

endmodule
